uarc_stream_bridge: RTL and testbench
=====================================

# uarc_stream_bridge

Synthesizable host-side partner for a single core0 UARC bus. It turns an external byte stream into UARC sends toward the core's receiver port. It also captures the core's sender-side sends into an outbound byte stream. Both directions are buffered. It replaces the behavioural stdin/stdout shim with RTL, so a core running uForth can talk to a host over valid/ready byte links.

## Interface
- WORD_MAG, 5, log2 of core word width; WORD_WIDTH = 1 << WORD_MAG
- FIFO_ADDR_WIDTH, 4, log2 of depth for each byte FIFO (default depth 16)
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- host_in_data  in  8  byte going toward the core
- host_in_valid  in  1  host_in_data is valid
- host_in_ready  out  1  inbound FIFO can accept a byte
- host_out_data  out  8  byte from the core
- host_out_valid  out  1  outbound FIFO is non-empty
- host_out_ready  in  1  host takes host_out_data
- bus_send_enable  in  1  this bus is selected by the core (sender_enables bit)
- bus_send  in  1  core is sending (global_send)
- bus_data  in  WORD_WIDTH  core send data (global_data)
- bus_send_ack  out  1  send accepted this cycle
- bus_recv_send  out  1  word offered to the core's receiver port
- bus_recv_data  out  WORD_WIDTH  offered word
- bus_recv_ack  in  1  core consumed the offered word at this edge
- trunc_err  out  1  sticky; set when an accepted bus_data has nonzero bits [WORD_WIDTH-1:8]
- in_count  out  FIFO_ADDR_WIDTH+1  inbound FIFO occupancy, 0..2^FIFO_ADDR_WIDTH
- out_count  out  FIFO_ADDR_WIDTH+1  outbound FIFO occupancy

## Operation
- Two independent circular FIFOs, depth D = 2^FIFO_ADDR_WIDTH, 8 bits wide. Each has read and write pointers of FIFO_ADDR_WIDTH bits that wrap modulo D, plus an occupancy counter.
- Inbound path:
  - Push when host_in_valid & host_in_ready.
  - host_in_ready = (in_count != D).
  - bus_recv_send = (in_count != 0).
  - bus_recv_data = {zeros, head byte}.
  - Pop when bus_recv_send & bus_recv_ack. An ack while bus_recv_send is 0 is ignored.
- Outbound path:
  - bus_send_ack = bus_send & bus_send_enable & (out_count != D). This is combinational, so the core sees the ack in the same cycle.
  - On an ack edge, push bus_data[7:0] into the outbound FIFO. If bus_data[WORD_WIDTH-1:8] != 0, set trunc_err.
  - host_out_valid = (out_count != 0); host_out_data = head byte.
  - Pop when host_out_valid & host_out_ready.
- With bus_send_enable low, bus_send_ack stays 0 and nothing is captured, whatever bus_send is.
- Simultaneous push and pop on the same FIFO: the count is unchanged and both pointers advance.
- A full FIFO never bypasses. Ready/ack stay low even if a pop happens the same cycle.
- An empty FIFO never bypasses. A byte pushed at edge N is visible no earlier than after edge N.
- trunc_err clears only on reset.
- The bridge inspects no values. Data order is preserved in both directions.

## Timing
- Reset asserted, any time including mid-transfer:
  - Pointers and counts go to 0; trunc_err goes to 0.
  - host_in_ready, host_out_valid, bus_send_ack, bus_recv_send are forced 0; bus_recv_data is forced 0.
  - Buffered bytes are discarded.
- First cycle after reset release: host_in_ready = 1 and all other outputs are 0.
- Inbound latency: a byte accepted at edge N gives bus_recv_send = 1 in cycle N+1.
- Outbound latency: a send acked at edge N gives host_out_valid = 1 in cycle N+1.
- Sustained throughput in each direction: one byte per cycle, provided the partner keeps its handshake high.
- The core holds bus_send/bus_data until it sees the ack. The bridge captures exactly once per cycle in which the ack is high.
- Pointer wrap: after D pushes, the write pointer returns to 0 with no bubble.

## Test plan
- Echo: push host bytes 0x48, 0x69 and have the core ack each one.
  - Required: bus_recv_data 0x48, then 0x69.
  - After the last pop: in_count = 0 and bus_recv_send = 0.
- Inbound full: with bus_recv_ack held 0, push 17 bytes 0x00..0x10.
  - Required: the first 16 are accepted and host_in_ready is 0 on the 17th; in_count = 16.
  - Then ack once; the next cycle has host_in_ready = 1 and head = 0x01.
- Outbound backpressure: hold host_out_ready 0 and drive bus_send with data 0x41 repeatedly.
  - Required: 16 acks, then bus_send_ack = 0 while bus_send stays high.
  - Pop one; next cycle the ack returns and the head is 0x41.
- Enable gating and truncation:
  - bus_send = 1 with bus_send_enable = 0 for 5 cycles gives no ack and out_count = 0.
  - Enable and send 0x0000_0142: host_out_data = 0x42 and trunc_err stays 1 until reset.
- Simultaneous and wrap: stream 40 bytes through each path with push and pop in the same cycle.
  - Required: the count stays constant, the output order matches the input, and no byte is lost across the pointer wrap.
- Mid-operation reset: with in_count = 5 and out_count = 3, pull reset low between clock edges.
  - Required: every output goes to its reset value immediately, without waiting for a clock edge.
  - After release, the first byte pushed is the first byte delivered.

Source files
------------

// File: rtl/uarc_stream_bridge_if.sv
// Handshake bundle between the stream bridge and its partners: host byte
// links on one side, the core0 UARC send/receive signals on the other.
interface uarc_stream_bridge_if #(
    parameter int WORD_MAG = 5
);
    localparam int WORD_WIDTH = 1 << WORD_MAG;

    logic [7:0]            host_in_data;
    logic                  host_in_valid;
    logic                  host_in_ready;
    logic [7:0]            host_out_data;
    logic                  host_out_valid;
    logic                  host_out_ready;
    logic                  bus_send_enable;
    logic                  bus_send;
    logic [WORD_WIDTH-1:0] bus_data;
    logic                  bus_send_ack;
    logic                  bus_recv_send;
    logic [WORD_WIDTH-1:0] bus_recv_data;
    logic                  bus_recv_ack;

    // Partner side: host and core drive the requests and consume the responses.
    modport master (
        output host_in_data, host_in_valid, host_out_ready,
        output bus_send_enable, bus_send, bus_data, bus_recv_ack,
        input  host_in_ready, host_out_data, host_out_valid,
        input  bus_send_ack, bus_recv_send, bus_recv_data
    );

    modport slave (
        input  host_in_data, host_in_valid, host_out_ready,
        input  bus_send_enable, bus_send, bus_data, bus_recv_ack,
        output host_in_ready, host_out_data, host_out_valid,
        output bus_send_ack, bus_recv_send, bus_recv_data
    );
endinterface

// File: rtl/uarc_stream_bridge.sv
// Host-side UARC partner: inbound byte FIFO feeding the core's receiver port,
// outbound byte FIFO capturing the core's sends for the host.
module uarc_stream_bridge #(
    parameter int WORD_MAG        = 5,
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    uarc_stream_bridge_if.slave      bus_if,
    output logic                     trunc_err_o,
    output logic [FIFO_ADDR_WIDTH:0] in_count_o,
    output logic [FIFO_ADDR_WIDTH:0] out_count_o
);
    localparam int WORD_WIDTH = 1 << WORD_MAG;
    localparam int DEPTH      = 1 << FIFO_ADDR_WIDTH;
    localparam logic [FIFO_ADDR_WIDTH:0] FULL  = (FIFO_ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [FIFO_ADDR_WIDTH:0] EMPTY = '0;

    logic [7:0]                 in_mem_q  [DEPTH];
    logic [7:0]                 out_mem_q [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] in_wr_q, in_wr_d, in_rd_q, in_rd_d;
    logic [FIFO_ADDR_WIDTH-1:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
    logic [FIFO_ADDR_WIDTH:0]   in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic                       trunc_q, trunc_d;
    logic                       in_push, in_pop, out_push, out_pop;
    logic                       in_avail, out_avail;

    // Push qualifiers look only at the current count, so a pop in the same
    // cycle never frees a slot early and an empty FIFO never bypasses.
    assign in_push   = bus_if.host_in_valid & (in_cnt_q != FULL);
    assign in_avail  = reset_n_i & (in_cnt_q != EMPTY);
    assign in_pop    = bus_if.bus_recv_ack & in_avail;
    assign out_push  = bus_if.bus_send & bus_if.bus_send_enable & (out_cnt_q != FULL);
    assign out_avail = reset_n_i & (out_cnt_q != EMPTY);
    assign out_pop   = bus_if.host_out_ready & out_avail;

    always_comb begin
        in_wr_d   = in_wr_q;
        in_rd_d   = in_rd_q;
        in_cnt_d  = in_cnt_q;
        out_wr_d  = out_wr_q;
        out_rd_d  = out_rd_q;
        out_cnt_d = out_cnt_q;
        trunc_d   = trunc_q;

        if (in_push) in_wr_d = in_wr_q + 1'b1;
        if (in_pop)  in_rd_d = in_rd_q + 1'b1;
        case ({in_push, in_pop})
            2'b10:   in_cnt_d = in_cnt_q + 1'b1;
            2'b01:   in_cnt_d = in_cnt_q - 1'b1;
            default: in_cnt_d = in_cnt_q;
        endcase

        if (out_push) out_wr_d = out_wr_q + 1'b1;
        if (out_pop)  out_rd_d = out_rd_q + 1'b1;
        case ({out_push, out_pop})
            2'b10:   out_cnt_d = out_cnt_q + 1'b1;
            2'b01:   out_cnt_d = out_cnt_q - 1'b1;
            default: out_cnt_d = out_cnt_q;
        endcase

        if (out_push && (|bus_if.bus_data[WORD_WIDTH-1:8])) trunc_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            in_wr_q   <= '0;
            in_rd_q   <= '0;
            in_cnt_q  <= '0;
            out_wr_q  <= '0;
            out_rd_q  <= '0;
            out_cnt_q <= '0;
            trunc_q   <= 1'b0;
        end else begin
            in_wr_q   <= in_wr_d;
            in_rd_q   <= in_rd_d;
            in_cnt_q  <= in_cnt_d;
            out_wr_q  <= out_wr_d;
            out_rd_q  <= out_rd_d;
            out_cnt_q <= out_cnt_d;
            trunc_q   <= trunc_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk_i) begin
        if (in_push)  in_mem_q[in_wr_q]   <= bus_if.host_in_data;
        if (out_push) out_mem_q[out_wr_q] <= bus_if.bus_data[7:0];
    end

    assign bus_if.host_in_ready  = reset_n_i & (in_cnt_q != FULL);
    assign bus_if.bus_recv_send  = in_avail;
    assign bus_if.bus_recv_data  = in_avail ? WORD_WIDTH'(in_mem_q[in_rd_q]) : '0;
    assign bus_if.bus_send_ack   = reset_n_i & out_push;
    assign bus_if.host_out_valid = out_avail;
    assign bus_if.host_out_data  = out_avail ? out_mem_q[out_rd_q] : '0;

    assign trunc_err_o = trunc_q;
    assign in_count_o  = in_cnt_q;
    assign out_count_o = out_cnt_q;
endmodule

// File: tb/tb_uarc_stream_bridge.sv
// Directed self-checking bench for uarc_stream_bridge: echo, full/backpressure,
// enable gating, truncation, wrap streaming and asynchronous mid-run reset.
module tb_uarc_stream_bridge;
    logic       clk;
    logic       rst_n;
    logic       trunc_err;
    logic [4:0] in_count;
    logic [4:0] out_count;
    int         total;
    int         bad;

    uarc_stream_bridge_if #(.WORD_MAG(5)) bif();

    uarc_stream_bridge #(
        .WORD_MAG        (5),
        .FIFO_ADDR_WIDTH (4)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (rst_n),
        .bus_if      (bif),
        .trunc_err_o (trunc_err),
        .in_count_o  (in_count),
        .out_count_o (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic idle();
        bif.host_in_data    = 8'h00;
        bif.host_in_valid   = 1'b0;
        bif.host_out_ready  = 1'b0;
        bif.bus_send_enable = 1'b0;
        bif.bus_send        = 1'b0;
        bif.bus_data        = 32'h0;
        bif.bus_recv_ack    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) tick();
        total++; if (bif.host_in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0h exp=0", bif.host_in_ready); end
        total++; if (bif.bus_recv_send !== 1'b0) begin bad++; $display("FAIL rst_recv_send got=%0h exp=0", bif.bus_recv_send); end
        total++; if (bif.host_out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0h exp=0", bif.host_out_valid); end
        rst_n = 1'b1;
        #1;
        total++; if (bif.host_in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready got=%0h exp=1", bif.host_in_ready); end
        total++; if (bif.bus_recv_send !== 1'b0) begin bad++; $display("FAIL rel_recv_send got=%0h exp=0", bif.bus_recv_send); end
        total++; if (bif.bus_recv_data !== 32'h0) begin bad++; $display("FAIL rel_recv_data got=%0h exp=0", bif.bus_recv_data); end
        total++; if (bif.host_out_valid !== 1'b0) begin bad++; $display("FAIL rel_out_valid got=%0h exp=0", bif.host_out_valid); end
        total++; if (bif.host_out_data !== 8'h00) begin bad++; $display("FAIL rel_out_data got=%0h exp=0", bif.host_out_data); end
        total++; if (bif.bus_send_ack !== 1'b0) begin bad++; $display("FAIL rel_send_ack got=%0h exp=0", bif.bus_send_ack); end
        total++; if (trunc_err !== 1'b0) begin bad++; $display("FAIL rel_trunc got=%0h exp=0", trunc_err); end
        total++; if (in_count !== 5'd0 || out_count !== 5'd0) begin bad++; $display("FAIL rel_counts got=%0d/%0d exp=0/0", in_count, out_count); end
        tick();
    endtask

    task automatic test_echo();
        bif.host_in_valid = 1'b1; bif.host_in_data = 8'h48;
        #1;
        total++; if (bif.host_in_ready !== 1'b1) begin bad++; $display("FAIL echo_ready got=%0h exp=1", bif.host_in_ready); end
        total++; if (bif.bus_recv_send !== 1'b0) begin bad++; $display("FAIL echo_no_bypass got=%0h exp=0", bif.bus_recv_send); end
        tick();
        bif.host_in_data = 8'h69; bif.bus_recv_ack = 1'b1;
        #1;
        total++; if (bif.bus_recv_send !== 1'b1) begin bad++; $display("FAIL echo_send1 got=%0h exp=1", bif.bus_recv_send); end
        total++; if (bif.bus_recv_data !== 32'h48) begin bad++; $display("FAIL echo_data1 got=%0h exp=48", bif.bus_recv_data); end
        tick();
        bif.host_in_valid = 1'b0;
        #1;
        total++; if (bif.bus_recv_data !== 32'h69) begin bad++; $display("FAIL echo_data2 got=%0h exp=69", bif.bus_recv_data); end
        total++; if (in_count !== 5'd1) begin bad++; $display("FAIL echo_count1 got=%0d exp=1", in_count); end
        tick();
        bif.bus_recv_ack = 1'b0;
        #1;
        total++; if (in_count !== 5'd0) begin bad++; $display("FAIL echo_count0 got=%0d exp=0", in_count); end
        total++; if (bif.bus_recv_send !== 1'b0) begin bad++; $display("FAIL echo_send0 got=%0h exp=0", bif.bus_recv_send); end
        tick();
    endtask

    task automatic test_in_full();
        idle();
        for (int i = 0; i <= 16; i++) begin
            bif.host_in_valid = 1'b1; bif.host_in_data = 8'(i);
            #1;
            total++; if (bif.host_in_ready !== (i < 16)) begin bad++; $display("FAIL full_ready[%0d] got=%0h exp=%0h", i, bif.host_in_ready, (i < 16)); end
            tick();
        end
        bif.host_in_valid = 1'b0;
        #1;
        total++; if (in_count !== 5'd16) begin bad++; $display("FAIL full_count got=%0d exp=16", in_count); end
        total++; if (bif.bus_recv_data !== 32'h00) begin bad++; $display("FAIL full_head0 got=%0h exp=0", bif.bus_recv_data); end
        bif.bus_recv_ack = 1'b1;
        tick();
        bif.bus_recv_ack = 1'b0;
        #1;
        total++; if (bif.host_in_ready !== 1'b1) begin bad++; $display("FAIL full_ready_back got=%0h exp=1", bif.host_in_ready); end
        total++; if (bif.bus_recv_data !== 32'h01) begin bad++; $display("FAIL full_head1 got=%0h exp=1", bif.bus_recv_data); end
        total++; if (in_count !== 5'd15) begin bad++; $display("FAIL full_count15 got=%0d exp=15", in_count); end
        tick();
        bif.bus_recv_ack = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            #1;
            total++; if (bif.bus_recv_data !== 32'(i)) begin bad++; $display("FAIL full_drain[%0d] got=%0h exp=%0h", i, bif.bus_recv_data, i); end
            tick();
        end
        bif.bus_recv_ack = 1'b0;
        #1;
        total++; if (in_count !== 5'd0) begin bad++; $display("FAIL full_drained got=%0d exp=0", in_count); end
        tick();
    endtask

    task automatic test_out_backpressure();
        idle();
        bif.bus_send_enable = 1'b1; bif.bus_send = 1'b1; bif.bus_data = 32'h41;
        for (int i = 0; i <= 16; i++) begin
            #1;
            total++; if (bif.bus_send_ack !== (i < 16)) begin bad++; $display("FAIL bp_ack[%0d] got=%0h exp=%0h", i, bif.bus_send_ack, (i < 16)); end
            tick();
        end
        #1;
        total++; if (out_count !== 5'd16) begin bad++; $display("FAIL bp_count got=%0d exp=16", out_count); end
        total++; if (bif.bus_send_ack !== 1'b0) begin bad++; $display("FAIL bp_ack_full got=%0h exp=0", bif.bus_send_ack); end
        bif.host_out_ready = 1'b1;
        #1;
        total++; if (bif.bus_send_ack !== 1'b0) begin bad++; $display("FAIL bp_no_bypass got=%0h exp=0", bif.bus_send_ack); end
        tick();
        bif.host_out_ready = 1'b0;
        #1;
        total++; if (bif.bus_send_ack !== 1'b1) begin bad++; $display("FAIL bp_ack_back got=%0h exp=1", bif.bus_send_ack); end
        total++; if (bif.host_out_data !== 8'h41) begin bad++; $display("FAIL bp_head got=%0h exp=41", bif.host_out_data); end
        total++; if (out_count !== 5'd15) begin bad++; $display("FAIL bp_count15 got=%0d exp=15", out_count); end
        tick();
        bif.bus_send = 1'b0; bif.host_out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            total++; if (bif.host_out_valid !== 1'b1 || bif.host_out_data !== 8'h41) begin bad++; $display("FAIL bp_drain[%0d] got=%0h/%0h exp=1/41", i, bif.host_out_valid, bif.host_out_data); end
            tick();
        end
        bif.host_out_ready = 1'b0;
        #1;
        total++; if (out_count !== 5'd0 || bif.host_out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%0d/%0h exp=0/0", out_count, bif.host_out_valid); end
        total++; if (trunc_err !== 1'b0) begin bad++; $display("FAIL bp_trunc got=%0h exp=0", trunc_err); end
        tick();
    endtask

    task automatic test_enable_trunc();
        idle();
        bif.bus_send = 1'b1; bif.bus_data = 32'h0000_0142;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (bif.bus_send_ack !== 1'b0) begin bad++; $display("FAIL en_gate[%0d] got=%0h exp=0", i, bif.bus_send_ack); end
            tick();
        end
        total++; if (out_count !== 5'd0) begin bad++; $display("FAIL en_count got=%0d exp=0", out_count); end
        bif.bus_send_enable = 1'b1;
        #1;
        total++; if (bif.bus_send_ack !== 1'b1) begin bad++; $display("FAIL en_ack got=%0h exp=1", bif.bus_send_ack); end
        tick();
        bif.bus_send = 1'b0; bif.bus_send_enable = 1'b0;
        #1;
        total++; if (bif.host_out_data !== 8'h42) begin bad++; $display("FAIL tr_data got=%0h exp=42", bif.host_out_data); end
        total++; if (out_count !== 5'd1) begin bad++; $display("FAIL tr_count got=%0d exp=1", out_count); end
        total++; if (trunc_err !== 1'b1) begin bad++; $display("FAIL tr_set got=%0h exp=1", trunc_err); end
        bif.host_out_ready = 1'b1;
        tick();
        bif.host_out_ready = 1'b0;
        repeat (3) tick();
        total++; if (trunc_err !== 1'b1 || out_count !== 5'd0) begin bad++; $display("FAIL tr_sticky got=%0h/%0d exp=1/0", trunc_err, out_count); end
    endtask

    task automatic test_stream_wrap();
        logic [7:0] exp_in;
        logic [7:0] exp_out;
        idle();
        bif.host_in_valid = 1'b1; bif.host_in_data = 8'h03;
        bif.bus_send_enable = 1'b1; bif.bus_send = 1'b1; bif.bus_data = 32'h05;
        tick();
        for (int k = 1; k <= 40; k++) begin
            exp_in  = 8'((k - 1) * 7 + 3);
            exp_out = 8'((k - 1) * 11 + 5);
            bif.host_in_data = 8'(k * 7 + 3);
            bif.bus_data     = {24'h0, 8'(k * 11 + 5)};
            bif.bus_recv_ack = 1'b1; bif.host_out_ready = 1'b1;
            #1;
            total++; if (in_count !== 5'd1 || bif.host_in_ready !== 1'b1) begin bad++; $display("FAIL wr_in_state[%0d] got=%0d/%0h exp=1/1", k, in_count, bif.host_in_ready); end
            total++; if (bif.bus_recv_data !== {24'h0, exp_in}) begin bad++; $display("FAIL wr_in_data[%0d] got=%0h exp=%0h", k, bif.bus_recv_data, exp_in); end
            total++; if (out_count !== 5'd1 || bif.bus_send_ack !== 1'b1) begin bad++; $display("FAIL wr_out_state[%0d] got=%0d/%0h exp=1/1", k, out_count, bif.bus_send_ack); end
            total++; if (bif.host_out_data !== exp_out) begin bad++; $display("FAIL wr_out_data[%0d] got=%0h exp=%0h", k, bif.host_out_data, exp_out); end
            tick();
        end
        bif.host_in_valid = 1'b0; bif.bus_send = 1'b0;
        #1;
        total++; if (bif.bus_recv_data !== 32'(8'(40 * 7 + 3))) begin bad++; $display("FAIL wr_in_last got=%0h exp=%0h", bif.bus_recv_data, 8'(40 * 7 + 3)); end
        total++; if (bif.host_out_data !== 8'(40 * 11 + 5)) begin bad++; $display("FAIL wr_out_last got=%0h exp=%0h", bif.host_out_data, 8'(40 * 11 + 5)); end
        tick();
        idle();
        #1;
        total++; if (in_count !== 5'd0 || out_count !== 5'd0) begin bad++; $display("FAIL wr_empty got=%0d/%0d exp=0/0", in_count, out_count); end
        tick();
    endtask

    task automatic test_mid_reset();
        idle();
        for (int i = 0; i < 5; i++) begin
            bif.host_in_valid = 1'b1; bif.host_in_data = 8'(8'hA0 + i);
            bif.bus_send_enable = 1'b1; bif.bus_send = (i < 3);
            bif.bus_data = 32'(8'hB0 + i);
            tick();
        end
        idle();
        #1;
        total++; if (in_count !== 5'd5 || out_count !== 5'd3) begin bad++; $display("FAIL mr_pre got=%0d/%0d exp=5/3", in_count, out_count); end
        #3;
        rst_n = 1'b0;
        bif.bus_send_enable = 1'b1; bif.bus_send = 1'b1; bif.bus_data = 32'h77;
        bif.host_in_valid = 1'b1; bif.host_in_data = 8'hEE;
        #1;
        total++; if (in_count !== 5'd0 || out_count !== 5'd0) begin bad++; $display("FAIL mr_counts got=%0d/%0d exp=0/0", in_count, out_count); end
        total++; if (bif.host_in_ready !== 1'b0 || bif.bus_recv_send !== 1'b0) begin bad++; $display("FAIL mr_in_side got=%0h/%0h exp=0/0", bif.host_in_ready, bif.bus_recv_send); end
        total++; if (bif.bus_recv_data !== 32'h0 || bif.host_out_data !== 8'h00) begin bad++; $display("FAIL mr_data got=%0h/%0h exp=0/0", bif.bus_recv_data, bif.host_out_data); end
        total++; if (bif.host_out_valid !== 1'b0 || bif.bus_send_ack !== 1'b0) begin bad++; $display("FAIL mr_out_side got=%0h/%0h exp=0/0", bif.host_out_valid, bif.bus_send_ack); end
        total++; if (trunc_err !== 1'b0) begin bad++; $display("FAIL mr_trunc got=%0h exp=0", trunc_err); end
        tick();
        total++; if (in_count !== 5'd0 || bif.host_in_ready !== 1'b0) begin bad++; $display("FAIL mr_held got=%0d/%0h exp=0/0", in_count, bif.host_in_ready); end
        rst_n = 1'b1;
        idle();
        #1;
        total++; if (bif.host_in_ready !== 1'b1 || bif.bus_recv_send !== 1'b0 || bif.host_out_valid !== 1'b0) begin bad++; $display("FAIL mr_release got=%0h/%0h/%0h exp=1/0/0", bif.host_in_ready, bif.bus_recv_send, bif.host_out_valid); end
        bif.host_in_valid = 1'b1; bif.host_in_data = 8'hC5;
        bif.bus_send_enable = 1'b1; bif.bus_send = 1'b1; bif.bus_data = 32'hD7;
        #1;
        tick();
        idle();
        #1;
        total++; if (bif.bus_recv_send !== 1'b1 || bif.bus_recv_data !== 32'hC5) begin bad++; $display("FAIL mr_first_in got=%0h/%0h exp=1/c5", bif.bus_recv_send, bif.bus_recv_data); end
        total++; if (bif.host_out_valid !== 1'b1 || bif.host_out_data !== 8'hD7) begin bad++; $display("FAIL mr_first_out got=%0h/%0h exp=1/d7", bif.host_out_valid, bif.host_out_data); end
        total++; if (in_count !== 5'd1 || out_count !== 5'd1) begin bad++; $display("FAIL mr_post_counts got=%0d/%0d exp=1/1", in_count, out_count); end
        bif.bus_recv_ack = 1'b1; bif.host_out_ready = 1'b1;
        tick();
        idle();
        #1;
        total++; if (in_count !== 5'd0 || out_count !== 5'd0) begin bad++; $display("FAIL mr_final got=%0d/%0d exp=0/0", in_count, out_count); end
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_echo();
        test_in_full();
        test_out_backpressure();
        test_enable_trunc();
        test_stream_wrap();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
